// File: rtl/hack_run_sequencer.sv
// Run controller for the HackCPU: streams a program into instruction ROM while the CPU is held
// in reset, then gates CPU advancement in free-run or single-step mode until the PC leaves the program.
module hack_run_sequencer #(
    parameter int ROM_AW = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_valid_i,
    input  logic [15:0]       load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    input  logic              free_run_i,
    input  logic              step_req_i,
    input  logic              restart_i,
    input  logic [15:0]       cpu_pc_i,
    output logic              cpu_reset_o,
    output logic              cpu_en_o,
    output logic              rom_we_o,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [15:0]       rom_wdata_o,
    output logic [ROM_AW:0]   prog_len_o,
    output logic [31:0]       cycle_count_o,
    output logic              halted_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CPURST = 3'd2,
        RUN    = 3'd3,
        HALT   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ROM_AW-1:0] wptr_q, wptr_d;
    logic [ROM_AW:0]   prog_len_q, prog_len_d;
    logic [31:0]       cycle_count_q, cycle_count_d;
    logic              step_req_q;
    logic              step_pulse;
    logic              pc_in_range;
    logic [15:0]       prog_len_ext;

    assign prog_len_ext = 16'(prog_len_q);
    assign pc_in_range  = cpu_pc_i < prog_len_ext;
    assign step_pulse   = step_req_i & ~step_req_q;

    // The step history is tracked in every state, so a request held through CPURST does not fire.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= IDLE;
            wptr_q        <= '0;
            prog_len_q    <= '0;
            cycle_count_q <= '0;
            step_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wptr_q        <= wptr_d;
            prog_len_q    <= prog_len_d;
            cycle_count_q <= cycle_count_d;
            step_req_q    <= step_req_i;
        end
    end

    always_comb begin
        state_d       = state_q;
        wptr_d        = wptr_q;
        prog_len_d    = prog_len_q;
        cycle_count_d = cycle_count_q;
        load_ready_o  = 1'b0;
        cpu_reset_o   = 1'b1;
        cpu_en_o      = 1'b0;
        rom_we_o      = 1'b0;
        halted_o      = 1'b0;

        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                load_ready_o = 1'b1;
                if (load_valid_i) begin
                    rom_we_o   = 1'b1;
                    wptr_d     = wptr_q + ROM_AW'(1);
                    prog_len_d = prog_len_q + (ROM_AW+1)'(1);
                    // Writing the top address fills the ROM, so the load ends without load_last.
                    if (load_last_i || (wptr_q == '1)) begin
                        state_d = CPURST;
                    end
                end
            end
            CPURST: begin
                cycle_count_d = '0;
                state_d       = RUN;
            end
            RUN: begin
                cpu_reset_o = 1'b0;
                if (restart_i) begin
                    state_d = CPURST;
                end else if (!pc_in_range) begin
                    state_d = HALT;
                end else if (free_run_i || step_pulse) begin
                    cpu_en_o = 1'b1;
                    if (cycle_count_q != '1) begin
                        cycle_count_d = cycle_count_q + 32'd1;
                    end
                end
            end
            HALT: begin
                cpu_reset_o = 1'b0;
                halted_o    = 1'b1;
                if (restart_i) begin
                    state_d = CPURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rom_addr_o    = wptr_q;
    assign rom_wdata_o   = load_data_i;
    assign prog_len_o    = prog_len_q;
    assign cycle_count_o = cycle_count_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_hack_run_sequencer.sv
// Bench for hack_run_sequencer: ROM writes go through a scoreboard queue; a tiny CPU model
// advances its PC on cpu_en. A second instance with ROM_AW=2 covers the ROM-full exit.
module tb_hack_run_sequencer;

    logic        clk;
    logic        reset_n;
    logic        load_valid, load_last, free_run, step_req, restart;
    logic [15:0] load_data;
    logic [15:0] pc_model;
    logic        load_ready, cpu_reset, cpu_en, rom_we, halted;
    logic [7:0]  rom_addr;
    logic [15:0] rom_wdata;
    logic [8:0]  prog_len;
    logic [31:0] cycle_count;
    logic [2:0]  state;

    logic        s_valid, s_last;
    logic [15:0] s_data;
    logic        s_load_ready, s_cpu_reset, s_cpu_en, s_rom_we, s_halted;
    logic [1:0]  s_rom_addr;
    logic [15:0] s_rom_wdata;
    logic [2:0]  s_prog_len;
    logic [31:0] s_cycle_count;
    logic [2:0]  s_state;

    int          checks = 0;
    int          errors = 0;
    int          en_count = 0;
    int          en_base;
    logic [7:0]  exp_addr;
    logic [23:0] sb_q[$];
    logic [23:0] sb_item;

    hack_run_sequencer #(.ROM_AW(8)) dut (
        .clk_i(clk), .reset_i(reset_n),
        .load_valid_i(load_valid), .load_data_i(load_data), .load_last_i(load_last),
        .load_ready_o(load_ready), .free_run_i(free_run), .step_req_i(step_req),
        .restart_i(restart), .cpu_pc_i(pc_model), .cpu_reset_o(cpu_reset),
        .cpu_en_o(cpu_en), .rom_we_o(rom_we), .rom_addr_o(rom_addr),
        .rom_wdata_o(rom_wdata), .prog_len_o(prog_len), .cycle_count_o(cycle_count),
        .halted_o(halted), .state_o(state)
    );

    hack_run_sequencer #(.ROM_AW(2)) dut_small (
        .clk_i(clk), .reset_i(reset_n),
        .load_valid_i(s_valid), .load_data_i(s_data), .load_last_i(s_last),
        .load_ready_o(s_load_ready), .free_run_i(1'b0), .step_req_i(1'b0),
        .restart_i(1'b0), .cpu_pc_i(16'h0000), .cpu_reset_o(s_cpu_reset),
        .cpu_en_o(s_cpu_en), .rom_we_o(s_rom_we), .rom_addr_o(s_rom_addr),
        .rom_wdata_o(s_rom_wdata), .prog_len_o(s_prog_len), .cycle_count_o(s_cycle_count),
        .halted_o(s_halted), .state_o(s_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cpu_reset)   pc_model <= 16'h0000;
        else if (cpu_en) pc_model <= pc_model + 16'd1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Every ROM write must match the oldest beat the bench drove.
    always @(negedge clk) begin
        if (cpu_en) en_count++;
        if (rom_we === 1'b1) begin
            if (sb_q.size() == 0) begin
                checkOutput("rom_we_unexpected", 32'd1, 32'd0);
            end else begin
                sb_item = sb_q.pop_front();
                checkOutput("rom_addr", 32'(rom_addr), 32'(sb_item[23:16]));
                checkOutput("rom_wdata", 32'(rom_wdata), 32'(sb_item[15:0]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        sb_q.push_back({exp_addr, data});
        exp_addr   = exp_addr + 8'd1;
        @(negedge clk);
        checkOutput("beat_load_ready", 32'(load_ready), 32'd1);
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = 16'h0;
        free_run = 1'b1; step_req = 1'b0; restart = 1'b0;
        s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0;
        exp_addr = 8'd0;
        pc_model = 16'h0;

        tick(); tick();
        @(negedge clk);
        checkOutput("rst_state", 32'(state), 32'd0);
        checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        checkOutput("rst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("rst_rom_we", 32'(rom_we), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_prog_len", 32'(prog_len), 32'd0);
        checkOutput("rst_cycle_count", cycle_count, 32'd0);
        checkOutput("rst_small_state", 32'(s_state), 32'd0);
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("release_idle", 32'(state), 32'd0);
        checkOutput("release_ready", 32'(load_ready), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("load_state", 32'(state), 32'd1);
        checkOutput("load_ready", 32'(load_ready), 32'd1);
        tick();

        applyStimulus(16'h0001, 1'b0);
        applyStimulus(16'hEC10, 1'b0);
        applyStimulus(16'h0003, 1'b1);
        @(negedge clk);
        checkOutput("cpurst_state", 32'(state), 32'd2);
        checkOutput("cpurst_ready", 32'(load_ready), 32'd0);
        checkOutput("cpurst_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("cpurst_cpu_en", 32'(cpu_en), 32'd0);
        checkOutput("prog_len_3", 32'(prog_len), 32'd3);
        tick();

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("fr_state", 32'(state), 32'd3);
            checkOutput("fr_cpu_en", 32'(cpu_en), 32'd1);
            checkOutput("fr_pc", 32'(pc_model), 32'(i));
            checkOutput("fr_cpu_reset", 32'(cpu_reset), 32'd0);
            tick();
        end
        @(negedge clk);
        checkOutput("halt_detect_en", 32'(cpu_en), 32'd0);
        checkOutput("halt_detect_halted", 32'(halted), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("halted", 32'(halted), 32'd1);
        checkOutput("halt_state", 32'(state), 32'd4);
        checkOutput("halt_cycle_count", cycle_count, 32'd3);
        checkOutput("halt_cpu_reset", 32'(cpu_reset), 32'd0);
        checkOutput("fr_en_pulses", 32'(en_count), 32'd3);
        tick();
        @(negedge clk);
        checkOutput("halt_stays", 32'(state), 32'd4);

        tick();
        free_run = 1'b0;
        restart  = 1'b1;
        tick();
        restart  = 1'b0;
        @(negedge clk);
        checkOutput("restart_cpurst", 32'(state), 32'd2);
        checkOutput("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("rerun_state", 32'(state), 32'd3);
        checkOutput("rerun_pc", 32'(pc_model), 32'd0);
        checkOutput("rerun_cycle_count", cycle_count, 32'd0);
        checkOutput("rerun_idle_en", 32'(cpu_en), 32'd0);

        en_base = en_count;
        for (int k = 0; k < 8; k++) begin
            tick();
            step_req = (k < 5 || k == 7);
        end
        tick();
        step_req = 1'b0;
        @(negedge clk);
        checkOutput("step_pulses", 32'(en_count - en_base), 32'd2);
        checkOutput("step_cycle_count", cycle_count, 32'd2);
        checkOutput("step_pc", 32'(pc_model), 32'd2);
        checkOutput("step_state", 32'(state), 32'd3);

        tick();
        restart  = 1'b1;
        step_req = 1'b1;
        @(negedge clk);
        checkOutput("collide_cpu_en", 32'(cpu_en), 32'd0);
        tick();
        restart = 1'b0;
        @(negedge clk);
        checkOutput("collide_cpurst", 32'(state), 32'd2);
        tick();
        @(negedge clk);
        checkOutput("collide_run", 32'(state), 32'd3);
        checkOutput("collide_cycle_count", cycle_count, 32'd0);
        checkOutput("held_step_no_fire", 32'(cpu_en), 32'd0);
        tick();
        step_req = 1'b0;

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_addr = 8'd0;
        tick();
        applyStimulus(16'h1111, 1'b0);
        applyStimulus(16'h2222, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp_addr = 8'd0;
        @(negedge clk);
        checkOutput("midload_state", 32'(state), 32'd0);
        checkOutput("midload_prog_len", 32'(prog_len), 32'd0);
        checkOutput("midload_cpu_reset", 32'(cpu_reset), 32'd1);
        checkOutput("midload_ready", 32'(load_ready), 32'd0);
        tick();
        applyStimulus(16'hABCD, 1'b1);
        @(negedge clk);
        checkOutput("reload_state", 32'(state), 32'd2);
        checkOutput("reload_prog_len", 32'(prog_len), 32'd1);

        tick();
        @(negedge clk);
        checkOutput("small_load_state", 32'(s_state), 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_last  = 1'b0;
            s_data  = 16'h0100 + 16'(i);
            @(negedge clk);
            checkOutput("small_rom_we", 32'(s_rom_we), 32'd1);
            checkOutput("small_rom_addr", 32'(s_rom_addr), 32'(i));
            checkOutput("small_rom_wdata", 32'(s_rom_wdata), 32'h100 + 32'(i));
            checkOutput("small_ready", 32'(s_load_ready), 32'd1);
            tick();
            s_valid = 1'b0;
        end
        @(negedge clk);
        checkOutput("full_state", 32'(s_state), 32'd2);
        checkOutput("full_prog_len", 32'(s_prog_len), 32'd4);
        checkOutput("full_ready", 32'(s_load_ready), 32'd0);
        checkOutput("full_rom_we", 32'(s_rom_we), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("full_run", 32'(s_state), 32'd3);

        checkOutput("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hack_run_sequencer.md
# hack_run_sequencer

Run controller for the HackCPU. It loads a program into instruction ROM over a valid/ready stream while holding the CPU in reset, then releases the CPU. It gates CPU advancement in free-run or single-step mode and halts when the PC runs past the loaded program. It sits between the host/loader port, the instruction ROM write port and the CPU reset/enable inputs.

## Interface
- `ROM_AW`, default 8: ROM address width. ROM depth is DEPTH = 2**ROM_AW words.
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low. 0 = reset.
- `load_valid`, in, 1: program word available.
- `load_data`, in, 16: program word.
- `load_last`, in, 1: qualifies the final word of the program.
- `load_ready`, out, 1: sequencer accepts a word; a beat transfers when `load_valid & load_ready`.
- `free_run`, in, 1: 1 = advance the CPU every cycle; 0 = single-step.
- `step_req`, in, 1: step request; the rising edge is used.
- `restart`, in, 1: re-run the loaded program from PC 0.
- `cpu_pc`, in, 16: current PC from the HackCPU.
- `cpu_reset`, out, 1: active-high reset to the HackCPU.
- `cpu_en`, out, 1: CPU advance strobe; CPU registers/PC update only on cycles with 1.
- `rom_we`, out, 1: ROM write strobe.
- `rom_addr`, out, ROM_AW: ROM write address.
- `rom_wdata`, out, 16: ROM write data, which is `load_data`.
- `prog_len`, out, ROM_AW+1: number of words loaded.
- `cycle_count`, out, 32: number of `cpu_en` cycles since the last CPURST.
- `halted`, out, 1: 1 while in HALT.
- `state`, out, 3: FSM state encoding, for debug.

## Operation
- **FSM states:** IDLE=0, LOAD=1, CPURST=2, RUN=3, HALT=4.
- **IDLE:**
  - `cpu_reset`=1, `load_ready`=0, `cpu_en`=0.
  - Always goes to LOAD on the next edge.
- **LOAD:**
  - `cpu_reset`=1, `load_ready`=1.
  - Each beat: `rom_we`=1, `rom_addr`=wptr, `wptr`/`prog_len` += 1.
  - Exit to CPURST after a beat with `load_last`=1, or after the beat written to address DEPTH-1 (ROM full, `prog_len`=DEPTH). Further `load_last` is not needed in the full case.
  - `restart`, `step_req` and `free_run` are ignored.
- **CPURST:**
  - `cpu_reset`=1 for exactly one cycle; `cycle_count` is cleared to 0.
  - Go to RUN.
- **RUN:**
  - `cpu_reset`=0.
  - `step_pulse` = `step_req` & ~`step_req_q`, where `step_req_q` is a register.
  - `cpu_en` = (`cpu_pc` < `prog_len`) & (`free_run` | `step_pulse`).
  - Compare is unsigned 16-bit, with `prog_len` zero-extended.
  - `cycle_count` += 1 on each `cpu_en`, saturating at 2^32-1.
  - If `cpu_pc` >= `prog_len`: `cpu_en`=0 that cycle and go to HALT.
  - If `restart`=1: go to CPURST, with `cpu_en`=0 that cycle.
- **HALT:**
  - `cpu_en`=0, `cpu_reset`=0 (CPU state kept for inspection), `halted`=1.
  - `restart`=1 goes to CPURST. Otherwise the sequencer stays in HALT.
- **Priority within RUN:** `restart` > halt detect > step/free-run.
- **Reprogramming:** requires `reset`. ROM contents are not cleared by this block.

## Timing
- **Reset:** `reset`=0 at an edge forces, on that edge:
  - state=IDLE, `wptr`=0, `prog_len`=0, `cycle_count`=0, `step_req_q`=0.
  - Outputs: `cpu_reset`=1, `cpu_en`=0, `rom_we`=0, `load_ready`=0, `halted`=0.
  - This holds from any state, including mid-LOAD; partially loaded words are discarded by `prog_len`=0.
- **Combinational outputs:** `load_ready`, `cpu_reset` and `halted` decode from state only. `rom_we`/`cpu_en` are combinational from state plus inputs.
- **Load latency:** first `load_ready` occurs 1 cycle after reset release (IDLE→LOAD). Throughput is 1 word/cycle.
- **Last beat:** the beat with `load_last` is followed by CPURST for 1 cycle. The first possible `cpu_en` comes 2 cycles after the last beat.
- **Single-step:** `step_req` held high for N cycles yields exactly one `cpu_en`, on the first cycle in RUN with `step_req_q`=0. `step_req_q` updates in every state, so a step held during CPURST does not fire on entering RUN.
- **Halt:** latency is 1 cycle from `cpu_pc` >= `prog_len` to `halted`=1. `cpu_en` is already 0 in the detecting cycle.
- **Restart:** latency is 1 cycle to CPURST and 2 cycles to RUN.

## Test plan
- **Load 3 words, last on the third:**
  - Words are 0x0001, 0xEC10, 0x0003; `load_last` on the third beat.
  - `rom_we` at addr 0, 1, 2 with matching data; `prog_len`=3.
  - State goes LOAD→CPURST (1 cycle)→RUN; `load_ready`=0 after the last beat.
- **Free-run:**
  - `free_run`=1; CPU model increments PC on `cpu_en`.
  - `cpu_en` is high for exactly 3 cycles (PC 0, 1, 2).
  - At PC=3: `cpu_en`=0, next cycle `halted`=1, `cycle_count`=3.
- **Single-step:**
  - `free_run`=0; `step_req` held high 5 cycles, then low 2, then high 1.
  - Exactly 2 `cpu_en` pulses; `cycle_count`=2.
- **ROM full:**
  - `ROM_AW`=2; 4 beats with `load_last`=0.
  - Load exits after the 4th beat; `prog_len`=4; `load_ready`=0 next cycle.
- **Restart collision:**
  - In RUN, `restart` and a `step_req` rising edge in the same cycle.
  - `cpu_en`=0, state goes to CPURST, then `cycle_count`=0.
  - From HALT, `restart` re-runs with PC 0.
- **Reset mid-LOAD:**
  - After 2 beats, drive `reset`=0 for 1 cycle.
  - State=IDLE, `prog_len`=0, `cpu_reset`=1.
  - A reload then writes from addr 0.
